// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers for the key schedule block.
//   AES_NR / AES_NK_BITS : round count and key width
//   aes_rcon(round)      : round constant byte for rounds 1..10
//   aes_sbox(byte)       : forward AES S-box
//   aes_state_e          : key-schedule controller state encoding
package aes_pkg;

    localparam int unsigned AES_NR      = 10;
    localparam int unsigned AES_NK_BITS = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } aes_state_e;

    // Row-major S-box; index 0 sits in the most significant byte.
    localparam logic [0:255][7:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step (combinational).
//   prev_key : previous round key, w0 in [127:96]
//   rcon     : round constant byte
//   next_key : following round key
module aes_key_round
    import aes_pkg::*;
(
    input  logic [AES_NK_BITS-1:0] prev_key,
    input  logic [7:0]             rcon,
    output logic [AES_NK_BITS-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot = {w3[23:0], w3[31:24]};

    // SubWord on the rotated word, then fold in the round constant.
    assign t = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
                aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])} ^ {rcon, 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer and round-key buffer.
//   clk, rst            : clock, synchronous active-high reset
//   key_valid/key       : cipher key offer; key_ready accepts it
//   keys_valid          : buffer holds the full schedule of the last key
//   busy / round        : expansion in progress / round being generated
//   rd_addr / rd_data   : registered read of round key 0..10 (0 beyond)
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [AES_NK_BITS-1:0] key,
    output logic                   key_ready,
    output logic                   keys_valid,
    output logic                   busy,
    output logic [3:0]             round,
    input  logic [3:0]             rd_addr,
    output logic [AES_NK_BITS-1:0] rd_data
);

    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    aes_state_e                     state, state_nxt;
    logic [3:0]                     round_q;
    logic [AES_NK_BITS-1:0]         cur;
    logic [AES_NK_BITS-1:0]         nxt_key;
    logic [AES_NR:0][AES_NK_BITS-1:0] rk;
    logic                           accept;

    aes_key_round u_round (
        .prev_key (cur),
        .rcon     (aes_rcon(round_q)),
        .next_key (nxt_key)
    );

    assign accept = key_valid && key_ready;
    assign round  = round_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (key_valid)            state_nxt = EXPAND;
            EXPAND:     if (round_q == LAST_RND)  state_nxt = DONE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Outputs are pure state decodes so they never see an input path.
    always_comb begin
        key_ready  = 1'b0;
        keys_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE:    key_ready = 1'b1;
            EXPAND:  busy      = 1'b1;
            DONE: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: buffer, running key, round counter, read port.
    // The read samples rk before this edge's write, so a same-index
    // read/write returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk      <= '0;
            cur     <= '0;
            round_q <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr <= LAST_RND) ? rk[rd_addr] : '0;
            if (accept) begin
                rk[0]   <= key;
                cur     <= key;
                round_q <= 4'd1;
            end else if (state == EXPAND) begin
                rk[round_q] <= nxt_key;
                cur         <= nxt_key;
                round_q     <= (round_q == LAST_RND) ? 4'd0 : round_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 reference vectors.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         keys_valid;
    logic         busy;
    logic [3:0]   round;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [127:0] fips_rk [0:10];

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .busy       (busy),
        .round      (round),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        fips_rk[0]  = K_FIPS;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; key_valid = 1'b0; key = '0; rd_addr = '0;
        tick; tick;
        chk("rst_rd",    rd_data,    0);
        chk("rst_busy",  busy,       0);
        chk("rst_kv",    keys_valid, 0);
        chk("rst_round", round,      0);
        rst = 1'b0;
        tick;
        chk("idle_ready", key_ready,  1);
        chk("idle_kv",    keys_valid, 0);

        // FIPS key: latency, round counter, full read sweep
        key_valid = 1'b1; key = K_FIPS;
        tick;
        key_valid = 1'b0;
        chk("a_busy",  busy,      1);
        chk("a_ready", key_ready, 0);
        chk("a_round", round,     1);
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("a_kv",    keys_valid, (k == 10));
            chk("a_round", round,      (k == 10) ? 0 : k + 1);
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick;
            chk("a_rd", rd_data, (a <= 10) ? fips_rk[a] : 128'h0);
        end

        // Zero key with a competing key held during expansion, then a
        // second key taken in the first DONE cycle
        key_valid = 1'b1; key = '0;
        tick;
        key = 128'hdeadbeefcafef00d0123456789abcdef;
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) begin
                chk("b_ready", key_ready, 0);
                chk("b_busy",  busy,      1);
            end
            tick;
        end
        chk("b_kv", keys_valid, 1);
        key = K_FIPS; rd_addr = 4'd1;
        tick;
        key_valid = 1'b0;
        chk("b_rd1",  rd_data,    Z_RK1);
        chk("b_kvlo", keys_valid, 0);
        chk("b_busy2", busy,      1);
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("c_kv", keys_valid, (k == 10));
        end
        rd_addr = 4'd10; tick;
        chk("c_rd10", rd_data, fips_rk[10]);
        rd_addr = 4'd0;  tick;
        chk("c_rd0",  rd_data, K_FIPS);

        // Zero key rerun for rk[10] and rk[0]
        key_valid = 1'b1; key = '0;
        tick;
        key_valid = 1'b0;
        repeat (10) tick;
        chk("d_kv", keys_valid, 1);
        rd_addr = 4'd10; tick;
        chk("d_rd10", rd_data, Z_RK10);
        rd_addr = 4'd0;  tick;
        chk("d_rd0",  rd_data, 0);
        rd_addr = 4'd1;  tick;
        chk("d_rd1",  rd_data, Z_RK1);

        // Reset in the middle of an expansion
        rd_addr = 4'd10;
        key_valid = 1'b1; key = K_FIPS;
        tick;
        key_valid = 1'b0;
        repeat (4) tick;
        chk("e_round5", round, 5);
        chk("e_busy",   busy,  1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("e_busy0",  busy,       0);
        chk("e_kv0",    keys_valid, 0);
        chk("e_ready",  key_ready,  1);
        chk("e_round0", round,      0);
        chk("e_rd",     rd_data,    0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : (i == 2) ? 4'd5 : 4'd10;
            tick;
            chk("e_rdclr", rd_data, 0);
        end
        chk("e_kvstay", keys_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
